// File: rtl/cache_pkg.sv
// Shared definitions for the data cache and its memory-side refill controller.
// Refill FSM states, store widths, opcodes and address field boundaries.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ_LO,
    WAIT_LO,
    REQ_HI,
    WAIT_HI,
    FILL,
    WRITE
  } refill_state_t;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // 8-byte blocks, 8 sets; the tag is everything above the set index
  localparam int OFF_LSB = 0;
  localparam int OFF_MSB = 2;
  localparam int SET_LSB = 3;
  localparam int SET_MSB = 5;
  localparam int TAG_LSB = 6;
  localparam int TAG_MSB = 31;

  function automatic logic [31:0] block_base(
    input logic [31:0] addr
  );
    return {addr[31:3], 3'b000};
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Places store data on the correct byte lanes of a 32-bit memory word
// and derives the matching byte enables from the store width.
module store_lane_align
  import cache_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  func3,
  input  logic [31:0] wd,
  output logic [3:0]  be,
  output logic [31:0] lane_wd
);

  // only the width field matters; bit 2 (unsigned loads) never reaches stores
  logic unused_f3;
  assign unused_f3 = func3[2];

  always_comb begin
    be      = 4'b0000;
    lane_wd = wd;
    unique case (func3[1:0])
      F3_SB[1:0]: begin
        be      = 4'b0001 << addr_lo;
        lane_wd = {4{wd[7:0]}};
      end
      F3_SH[1:0]: begin
        be      = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_wd = {2{wd[15:0]}};
      end
      F3_SW[1:0]: begin
        be      = 4'b1111;
        lane_wd = wd;
      end
      default: begin
        be      = 4'b0000;
        lane_wd = wd;
      end
    endcase
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Memory-side controller under the data cache: two-word block refill on a
// miss and single-cycle write-through of every store, stalling the pipeline.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WIDTH = 2 * DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   miss_req,
  input  logic [31:0]            miss_addr,
  input  logic                   st_req,
  input  logic [31:0]            st_addr,
  input  logic [DATA_WIDTH-1:0]  st_wd,
  input  logic [2:0]             st_func3,
  output logic                   stall,
  output logic [BLOCK_WIDTH-1:0] block_rd,
  output logic                   fill_valid,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [31:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_wd,
  output logic [3:0]             mem_be,
  input  logic [DATA_WIDTH-1:0]  mem_rdata,
  input  logic                   mem_rvalid
);

  refill_state_t state;
  logic [3:0]    be;
  logic [31:0]   lane_wd;
  logic          unused_addr;

  assign unused_addr = ^miss_addr[2:0];

  store_lane_align u_align (
    .addr_lo (st_addr[1:0]),
    .func3   (st_func3),
    .wd      (st_wd),
    .be      (be),
    .lane_wd (lane_wd)
  );

  // request/fill strobes are set on the transition into their state
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      block_rd   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      fill_valid <= 1'b0;
    end else begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      fill_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (miss_req) begin
            state   <= REQ_LO;
            mem_req <= 1'b1;
          end else if (st_req) begin
            state   <= WRITE;
            mem_req <= 1'b1;
            mem_we  <= 1'b1;
          end
        end
        REQ_LO: state <= WAIT_LO;
        WAIT_LO: begin
          if (mem_rvalid) begin
            block_rd[DATA_WIDTH-1:0] <= mem_rdata;
            state   <= REQ_HI;
            mem_req <= 1'b1;
          end
        end
        REQ_HI: state <= WAIT_HI;
        WAIT_HI: begin
          if (mem_rvalid) begin
            block_rd[BLOCK_WIDTH-1:DATA_WIDTH] <= mem_rdata;
            state      <= FILL;
            fill_valid <= 1'b1;
          end
        end
        FILL:    state <= IDLE;
        WRITE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // WRITE is the one busy state that lets the pipeline advance
  assign stall = (state == IDLE) ? (miss_req | st_req)
                                 : (state != WRITE);

  always_comb begin
    unique case (state)
      REQ_HI:  mem_addr = {miss_addr[31:3], 3'b100};
      WRITE:   mem_addr = {st_addr[31:2], 2'b00};
      default: mem_addr = {miss_addr[31:3], 3'b000};
    endcase
  end

  assign mem_be = (state == WRITE) ? be : 4'b0000;
  assign mem_wd = lane_wd;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: pipeline driver, latency-randomised
// memory responder and a monitor popping expected memory/fill traffic.
module tb_cache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_req = 1'b0;
  logic [31:0] miss_addr = '0;
  logic        st_req = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_wd = '0;
  logic [2:0]  st_func3 = '0;
  logic        stall;
  logic [63:0] block_rd;
  logic        fill_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;

  always #5 clk = ~clk;

  cache_refill_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .miss_req   (miss_req),
    .miss_addr  (miss_addr),
    .st_req     (st_req),
    .st_addr    (st_addr),
    .st_wd      (st_wd),
    .st_func3   (st_func3),
    .stall      (stall),
    .block_rd   (block_rd),
    .fill_valid (fill_valid),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .mem_be     (mem_be),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid)
  );

  // kind: 0 read, 1 write, 2 fill
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [63:0] blk;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [logic [31:0]];
  int          checks = 0;
  int          errors = 0;
  int          force_lat = 0;
  int          rd_seen = 0;
  logic [31:0] last_addr;
  logic [3:0]  last_be;
  logic [31:0] last_wd;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E3779B1) ^ 32'h0F1E2D3C;
  endfunction

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic void lane_model(input logic [31:0] a,
                                     input logic [2:0] f3,
                                     input logic [31:0] wd,
                                     output logic [3:0] be,
                                     output logic [31:0] w);
    int off;
    off = int'(a % 4);
    case (f3[1:0])
      2'd0: begin
        be = 4'(1 << off);
        w  = {24'b0, wd[7:0]} * 32'h01010101;
      end
      2'd1: begin
        be = (off >= 2) ? 4'hC : 4'h3;
        w  = {16'b0, wd[15:0]} * 32'h00010001;
      end
      2'd2: begin
        be = 4'hF;
        w  = wd;
      end
      default: begin
        be = 4'h0;
        w  = 32'h0;
      end
    endcase
  endfunction

  // memory: answers each read after 1..4 cycles, may pulse junk rvalid after
  initial begin
    bit          pend;
    bit          spur;
    int          cnt;
    logic [31:0] paddr;
    pend = 0;
    spur = 0;
    cnt  = 0;
    paddr = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (pend) cnt--;
      if (pend && cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd_word(paddr);
        pend = 0;
        spur = ($urandom % 2) == 1;
      end else if (spur) begin
        mem_rvalid = 1'b1;
        spur = 0;
      end
      @(negedge clk);
      if (!rst && mem_req && !mem_we) begin
        pend  = 1;
        paddr = mem_addr;
        cnt   = (force_lat > 0) ? force_lat : $urandom_range(1, 4);
        rd_seen++;
      end
    end
  end

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && mem_req) begin
        check("req_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("req_kind", {31'b0, mem_we}, e.kind);
          check("req_addr", mem_addr, e.addr);
          if (mem_we) begin
            last_addr = mem_addr;
            last_be   = mem_be;
            last_wd   = mem_wd;
            check("wr_be", mem_be, e.be);
            if (e.be != 0) check("wr_wd", mem_wd, e.wd);
            if (e.kind == 1) begin
              logic [31:0] w;
              w = rd_word(e.addr);
              for (int i = 0; i < 4; i++)
                if (e.be[i]) w[8*i +: 8] = e.wd[8*i +: 8];
              mem[e.addr] = w;
            end
          end
        end
      end
      if (!rst && fill_valid) begin
        check("fill_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("fill_kind", 2, e.kind);
          check("block_rd", block_rd, e.blk);
        end
      end
    end
  end

  task automatic run_op(input bit is_miss, input bit is_store,
                        input logic [31:0] maddr,
                        input logic [31:0] saddr,
                        input logic [2:0] f3,
                        input logic [31:0] wd,
                        output int stalls);
    exp_t        e;
    logic [31:0] base;
    bit          filled;
    bit          done;
    bit          s;
    bit          fv;
    base = {maddr[31:3], 3'b000};
    if (is_miss) begin
      e = '{0, base, 4'h0, 32'h0, 64'h0};
      sb.push_back(e);
      e.addr = base + 4;
      sb.push_back(e);
      e = '{2, 32'h0, 4'h0, 32'h0,
            {rd_word(base + 4), rd_word(base)}};
      sb.push_back(e);
    end
    if (is_store) begin
      e = '{1, saddr & ~32'h3, 4'h0, 32'h0, 64'h0};
      lane_model(saddr, f3, wd, e.be, e.wd);
      sb.push_back(e);
    end
    miss_addr = maddr;
    st_addr   = saddr;
    st_func3  = f3;
    st_wd     = wd;
    filled = !is_miss;
    done   = 0;
    stalls = 0;
    for (int c = 0; c < 200; c++) begin
      miss_req = is_miss && !filled;
      st_req   = is_store;
      @(negedge clk);
      s  = stall;
      fv = fill_valid;
      @(posedge clk);
      #1;
      if (s) stalls++;
      if (fv) filled = 1;
      if (!s) begin
        done = 1;
        break;
      end
    end
    check("op_done", done, 1);
    miss_req = 0;
    st_req   = 0;
  endtask

  task automatic reset_mid_refill();
    int  base_rd;
    bit  reached;
    exp_t e;
    force_lat = 4;
    base_rd = rd_seen;
    e = '{0, 32'h400, 4'h0, 32'h0, 64'h0};
    sb.push_back(e);
    e.addr = 32'h404;
    sb.push_back(e);
    miss_addr = 32'h0000_0400;
    miss_req  = 1;
    reached = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      if (rd_seen - base_rd == 2) begin
        reached = 1;
        break;
      end
    end
    check("rst_reach_hi", rd_seen - base_rd, 2);
    check("rst_in_wait_hi", {63'b0, stall}, 1);
    rst      = 1;
    miss_req = 0;
    @(posedge clk);
    #1;
    rst = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("rst_stall_low", {63'b0, stall}, 0);
      check("rst_no_fill", {63'b0, fill_valid}, 0);
      @(posedge clk);
      #1;
    end
    sb.delete();
    force_lat = 0;
  endtask

  initial begin
    int          st;
    int          kind;
    logic [31:0] a;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_stall", {63'b0, stall}, 0);
    check("rst_fill", {63'b0, fill_valid}, 0);
    check("rst_req", {63'b0, mem_req}, 0);
    check("rst_we", {63'b0, mem_we}, 0);
    check("rst_be", {60'b0, mem_be}, 0);
    check("rst_block", block_rd, 0);
    @(posedge clk);
    #1;
    rst = 0;

    mem[32'h108] = 32'h1111_2222;
    mem[32'h10C] = 32'h3333_4444;
    force_lat = 1;
    run_op(1, 0, 32'h108, 0, 3'b010, 0, st);
    check("lm_lat1_stall", st, 6);
    check("lm_lat1_block", block_rd, 64'h3333_4444_1111_2222);

    force_lat = 4;
    run_op(1, 0, 32'h108, 0, 3'b010, 0, st);
    check("lm_lat4_stall", st, 12);

    force_lat = 1;
    run_op(0, 1, 0, 32'h203, 3'b000, 32'h0000_00A5, st);
    check("sb_hit_stall", st, 1);
    check("sb_hit_addr", last_addr, 32'h200);
    check("sb_hit_be", last_be, 4'b1000);
    check("sb_hit_wd", last_wd, 32'hA5A5_A5A5);

    run_op(1, 1, 32'h30E, 32'h30E, 3'b001, 32'h0000_BEEF, st);
    check("sh_miss_stall", st, 7);
    check("sh_miss_addr", last_addr, 32'h30C);
    check("sh_miss_be", last_be, 4'b1100);

    reset_mid_refill();

    force_lat = 0;
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 2);
      a    = 32'($urandom_range(0, 1023));
      run_op(kind != 1, kind != 0, a, a,
             3'($urandom_range(0, 3)), $urandom, st);
      if ($urandom % 4 == 0) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (8) @(posedge clk);
    check("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
